err_sched_ctrl: RTL and testbench

ERR_SCHED_CTRL -- requirements
Module: err_sched_ctrl

---
 rtl/err_sched_pkg.sv | 17 +
 rtl/err_pri_pick.sv | 27 ++
 rtl/err_sched_ctrl.sv | 134 +++++++++++++
 tb/tb_err_sched_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_sched_pkg.sv
// Shared constants and types for the error scheduler.
// Optional feature macro: ERR_SCHED_OVF_EN (adds the ovf_cnt overflow counter).
package err_sched_pkg;

  localparam int NUM_ERR = 32;
  localparam int IDX_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // map[r] is the error index served at rank r (rank 0 = highest priority).
  typedef logic [NUM_ERR-1:0][IDX_W-1:0] map_t;

endpackage

// File: rtl/err_pri_pick.sv
// Combinational rank scan: finds the lowest rank whose mapped index is pending.
module err_pri_pick
  import err_sched_pkg::*;
(
  input  logic [NUM_ERR-1:0] i_pending,
  input  map_t               i_map,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_rank,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan from the lowest-priority rank upward so the lowest matching rank is left last.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    o_found = 1'b0;
    o_rank  = '0;
    o_idx   = '0;
    for (int r = NUM_ERR - 1; r >= 0; r--) begin
      if (i_pending[i_map[r]]) begin
        o_found = 1'b1;
        o_rank  = IDX_W'(r);
        o_idx   = i_map[r];
      end
    end
  end

endmodule

// File: rtl/err_sched_ctrl.sv
// Error scheduler: sticky pending vector, programmable rank->index priority
// map, and an IDLE -> ARB -> PRESENT FSM with a valid/ready output.
// Optional feature macro: ERR_SCHED_OVF_EN (8-bit saturating ovf_cnt output).
module err_sched_ctrl #(
  parameter int NUM_ERR = err_sched_pkg::NUM_ERR,
  parameter int IDX_W   = err_sched_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_ERR-1:0] err_in,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [IDX_W-1:0]   cfg_wdata,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [IDX_W-1:0]   out_rank,
  output logic [NUM_ERR-1:0] pending,
  output logic               busy,
  output logic               cfg_err,
  output logic               unmapped
`ifdef ERR_SCHED_OVF_EN
  ,
  output logic [7:0]         ovf_cnt
`endif
);

  import err_sched_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  map_t               r_map;
  logic [NUM_ERR-1:0] r_pending;
  logic [NUM_ERR-1:0] w_clr;
  logic [NUM_ERR-1:0] w_mapped;
  logic [IDX_W-1:0]   r_out_idx;
  logic [IDX_W-1:0]   r_out_rank;
  logic               r_cfg_err;
  logic               w_hs;
  logic               w_found;
  logic [IDX_W-1:0]   w_rank;
  logic [IDX_W-1:0]   w_idx;

  assign w_hs  = (r_state == ST_PRESENT) && out_ready;
  assign w_clr = w_hs ? (NUM_ERR'(1) << r_out_idx) : '0;

  err_pri_pick u_pick (
    .i_pending (r_pending),
    .i_map     (r_map),
    .o_found   (w_found),
    .o_rank    (w_rank),
    .o_idx     (w_idx)
  );

  // Next-state logic; a handshake returns to ARB only while enabled and work remains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (en && (|r_pending)) w_state_nxt = ST_ARB;
      ST_ARB:     w_state_nxt = w_found ? ST_PRESENT : ST_IDLE;
      ST_PRESENT: if (out_ready) w_state_nxt = (en && (|(r_pending & ~w_clr))) ? ST_ARB : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, sticky pending bits (set beats clear) and the latched winner.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_out_idx  <= '0;
      r_out_rank <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (r_pending & ~w_clr) | err_in;
      if ((r_state == ST_ARB) && w_found) begin
        r_out_idx  <= w_idx;
        r_out_rank <= w_rank;
      end
    end
  end

  // Priority-map writes land only in IDLE; anything else is flagged one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
      // NOTE: the map is a small flop array that must come up as identity, so it is reset explicitly.
      for (int r = 0; r < NUM_ERR; r++) r_map[r] <= IDX_W'(r);
    end else begin
      r_cfg_err <= cfg_we && (r_state != ST_IDLE);
      if (cfg_we && (r_state == ST_IDLE)) r_map[cfg_addr] <= cfg_wdata;
    end
  end

  // Indices reachable through at least one rank; pending bits outside this set can never be served.
  always_comb begin
    w_mapped = '0;
    for (int r = 0; r < NUM_ERR; r++) w_mapped[r_map[r]] = 1'b1;
  end

  assign out_valid = (r_state == ST_PRESENT);
  assign out_idx   = r_out_idx;
  assign out_rank  = r_out_rank;
  assign pending   = r_pending;
  assign busy      = (r_state != ST_IDLE);
  assign cfg_err   = r_cfg_err;
  assign unmapped  = |(r_pending & ~w_mapped);

`ifdef ERR_SCHED_OVF_EN
  logic [NUM_ERR-1:0] w_ovf_hit;
  logic [8:0]         w_ovf_sum;
  logic [7:0]         r_ovf_cnt;

  // An error re-asserted while already pending and not being cleared is an overflow.
  assign w_ovf_hit = err_in & r_pending & ~w_clr;

  // Add this cycle's overflow count to the running total.
  always_comb begin
    w_ovf_sum = {1'b0, r_ovf_cnt};
    for (int i = 0; i < NUM_ERR; i++) w_ovf_sum = w_ovf_sum + 9'(w_ovf_hit[i]);
  end

  // Saturating overflow counter.
  always_ff @(posedge clk) begin
    if (rst) r_ovf_cnt <= '0;
    else     r_ovf_cnt <= w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_err_sched_ctrl.sv
// Directed bench for err_sched_ctrl; expected values are hand-derived.
// Optional feature macro: ERR_SCHED_OVF_EN (adds the ovf_cnt checks).
module tb_err_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] err_in;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [4:0]  cfg_wdata;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [4:0]  out_rank;
  logic [31:0] pending;
  logic        busy;
  logic        cfg_err;
  logic        unmapped;
`ifdef ERR_SCHED_OVF_EN
  logic [7:0]  ovf_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  err_sched_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .err_in    (err_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_rank  (out_rank),
    .pending   (pending),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .unmapped  (unmapped)
`ifdef ERR_SCHED_OVF_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [4:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [4:0] rank_tbl [9] = '{5'd31, 5'd29, 5'd1, 5'd11, 5'd21, 5'd10, 5'd9, 5'd3, 5'd2};

  initial begin
    rst = 1'b1; en = 1'b0; err_in = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; out_ready = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_idx",      32'(out_idx),   32'd0);
    check("rst_rank",     32'(out_rank),  32'd0);
    check("rst_pending",  pending,        32'd0);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_cfg_err",  32'(cfg_err),   32'd0);
    check("rst_unmapped", 32'(unmapped),  32'd0);
    rst = 1'b0;

    // Identity map, two errors, latency T+2, drained in rank order
    en = 1'b1; out_ready = 1'b1; err_in = 32'h0000_0044;
    tick();
    err_in = '0;
    check("lat_pending_T",  pending,        32'h44);
    check("lat_valid_T",    32'(out_valid), 32'd0);
    tick();
    check("lat_valid_T1",   32'(out_valid), 32'd0);
    check("lat_busy_T1",    32'(busy),      32'd1);
    tick();
    check("first_valid",    32'(out_valid), 32'd1);
    check("first_idx",      32'(out_idx),   32'd2);
    check("first_rank",     32'(out_rank),  32'd2);
    tick();
    check("rearb_valid",    32'(out_valid), 32'd0);
    check("rearb_pending",  pending,        32'h40);
    tick();
    check("second_idx",     32'(out_idx),   32'd6);
    check("second_valid",   32'(out_valid), 32'd1);
    tick();
    check("drain_pending",  pending,        32'd0);
    check("drain_busy",     32'(busy),      32'd0);

    // Stall: index 9 presented, bit 7 (higher priority) pulses meanwhile
    out_ready = 1'b0; err_in = 32'h0000_0200;
    tick();
    err_in = '0;
    tick();
    tick();
    check("stall_idx0", 32'(out_idx), 32'd9);
    for (int k = 0; k < 5; k++) begin
      err_in = (k % 2 == 0) ? 32'h80 : 32'h0;
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx",   32'(out_idx),   32'd9);
      check("stall_rank",  32'(out_rank),  32'd9);
    end
    err_in = '0;
    check("stall_pending", pending, 32'h280);

    // Config write while busy is rejected
    cfg_write(5'd0, 5'd20);
    check("busy_cfg_err",  32'(cfg_err), 32'd1);
    tick();
    check("cfg_err_pulse", 32'(cfg_err), 32'd0);
    out_ready = 1'b1;
    tick();
    check("hs9_valid", 32'(out_valid), 32'd0);
    tick();
    check("bit7_idx",  32'(out_idx),   32'd7);
    check("bit7_rank", 32'(out_rank),  32'd7);
    tick();
    check("bit7_drain_busy", 32'(busy), 32'd0);

    // Map rank 0 still points at index 0
    err_in = 32'h1;
    tick();
    err_in = '0;
    tick();
    tick();
    check("map_kept_idx",  32'(out_idx),  32'd0);
    check("map_kept_rank", 32'(out_rank), 32'd0);
    tick();

    // Same write in IDLE is applied: rank 0 -> index 20 (duplicate of rank 20)
    cfg_write(5'd0, 5'd20);
    check("idle_cfg_err", 32'(cfg_err), 32'd0);
    err_in = 32'h0010_0001;
    tick();
    err_in = '0;
    tick();
    tick();
    check("dup_idx",  32'(out_idx),  32'd20);
    check("dup_rank", 32'(out_rank), 32'd0);
    tick();
    check("dup_pending",  pending,       32'h1);
    check("dup_unmapped", 32'(unmapped), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("dup_once_valid", 32'(out_valid), 32'd0);
    end
    do_reset();

    // Programmed priority map, mixed error vector
    for (int r = 0; r < 9; r++) begin
      cfg_write(5'(r), rank_tbl[r]);
      check("map_wr_cfg_err", 32'(cfg_err), 32'd0);
    end
    err_in = 32'hc18f_0044;
    tick();
    err_in = '0;
    tick();
    tick();
    check("pmap_first_idx",  32'(out_idx),  32'd31);
    check("pmap_first_rank", 32'(out_rank), 32'd0);
    tick();
    tick();
    check("pmap_second_idx",  32'(out_idx),  32'd2);
    check("pmap_second_rank", 32'(out_rank), 32'd8);
    check("pmap_unmapped",    32'(unmapped), 32'd1);
    do_reset();

    // All ranks map to index 0; index 4 can never be served
    for (int r = 0; r < 32; r++) cfg_write(5'(r), 5'd0);
    err_in = 32'h10;
    tick();
    err_in = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("nomap_valid", 32'(out_valid), 32'd0);
    end
    check("nomap_unmapped", 32'(unmapped), 32'd1);
    check("nomap_pending",  pending,       32'h10);
    do_reset();

    // Reset while presenting drops the output and the error
    out_ready = 1'b0; err_in = 32'h8;
    tick();
    err_in = '0;
    tick();
    tick();
    check("midrst_idx_pre", 32'(out_idx), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid",   32'(out_valid), 32'd0);
    check("midrst_pending", pending,        32'd0);
    check("midrst_idx",     32'(out_idx),   32'd0);

    // en dropped in PRESENT; set wins over a same-cycle clear
    err_in = 32'h6;
    tick();
    err_in = '0;
    tick();
    tick();
    check("en_idx", 32'(out_idx), 32'd1);
    en = 1'b0;
    tick();
    check("en_off_valid", 32'(out_valid), 32'd1);
    check("en_off_idx",   32'(out_idx),   32'd1);
    out_ready = 1'b1; err_in = 32'h2;
    tick();
    err_in = '0;
    check("en_off_busy",    32'(busy), 32'd0);
    check("set_wins",       pending,   32'h6);
    tick();
    check("en_off_stay",    32'(busy), 32'd0);
    en = 1'b1;
    tick();
    tick();
    check("resume_idx1", 32'(out_idx), 32'd1);
    tick();
    tick();
    check("resume_idx2", 32'(out_idx), 32'd2);
    tick();
    check("resume_pending", pending, 32'd0);

`ifdef ERR_SCHED_OVF_EN
    do_reset();
    check("ovf_rst", 32'(ovf_cnt), 32'd0);
    out_ready = 1'b0; err_in = 32'h8;
    for (int k = 0; k < 10; k++) tick();
    check("ovf_ten", 32'(ovf_cnt), 32'd9);
    for (int k = 0; k < 300; k++) tick();
    check("ovf_sat", 32'(ovf_cnt), 32'd255);
    err_in = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
